util_ext_sync_mc: RTL and testbench
===================================

Name: util_ext_sync_mc

Overview:
- Multi-channel successor to the single-bit external-sync arming block.
- Brings an asynchronous external SYSREF/trigger pin into the `clk` domain and detects a configurable edge on it.
- Gates that edge independently per channel through an arm/disarm state machine.
- Emits one-cycle `sync_out` pulses to downstream JESD204 link/transport logic, in one-shot or continuous (re-arming with holdoff) mode.

Parameters:
- ENABLED, 1: 0 ties every output to 0 permanently; no state machines are instantiated.
- NUM_CHANNELS, 1: number of independently armed channels (1..16).
- SYNC_STAGES, 3: synchronizer flops on `sync_in` (2..5).
- EDGE_MODE, 0: 0 = rising, 1 = falling, 2 = both edges of synchronized `sync_in`.
- ONE_SHOT, 1: 1 = channel disarms itself after firing; 0 = continuous with holdoff.
- HOLDOFF_WIDTH, 8: width of the holdoff counter and `holdoff_cycles`.
- COUNT_WIDTH, 16: width of `event_count`.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- ext_sync_arm  in  NUM_CHANNELS  per-channel arm request, level-sampled each cycle.
- ext_sync_disarm  in  NUM_CHANNELS  per-channel disarm request.
- sync_in  in  1  asynchronous external sync input.
- holdoff_cycles  in  HOLDOFF_WIDTH  quasi-static; sampled when a channel fires (continuous mode only).
- sync_armed  out  NUM_CHANNELS  channel is in ARMED or HOLDOFF.
- sync_out  out  NUM_CHANNELS  one-cycle pulse per qualified edge on an armed channel.
- sync_fired  out  NUM_CHANNELS  sticky: channel has fired since it was last armed.
- event_count  out  COUNT_WIDTH  count of detected edges, independent of arming; wraps to 0.

Behaviour:
- Reset (async assert, sync release): synchronizer chain, edge-detect flop, all states = IDLE, `sync_armed` = 0, `sync_out` = 0, `sync_fired` = 0, `event_count` = 0.
- Synchronizer: `sync_s` = output of stage SYNC_STAGES; `sync_s_d` = one further flop.
- Edge detection is combinational from `sync_s` and `sync_s_d`:
  - rising = `sync_s & ~sync_s_d`
  - falling = `~sync_s & sync_s_d`
  - both = XOR of the two
- Latency: if `sync_in` changes before clk edge E0, `sync_out` is high for exactly the cycle following edge E0+SYNC_STAGES.
- `event_count` increments on that same edge for every detected edge, in any channel state; wraps at 2^COUNT_WIDTH.
- Per-channel FSM states: IDLE, ARMED, HOLDOFF.
  - IDLE: arm -> ARMED.
  - ARMED + edge: assert `sync_out` next cycle, set `sync_fired`.
    - ONE_SHOT=1 -> IDLE.
    - ONE_SHOT=0 with `holdoff_cycles`=0 -> stay ARMED.
    - ONE_SHOT=0 otherwise -> HOLDOFF, counter loaded with `holdoff_cycles`.
  - HOLDOFF: counter decrements each cycle; edges are ignored and never produce `sync_out`; counter reaching 1 -> ARMED on the next edge of clk.
  - Net effect: exactly `holdoff_cycles` cycles are spent in HOLDOFF.
- Priority, per channel per cycle, highest first:
  1. Arm: from any state -> ARMED; clears `sync_fired`; aborts holdoff; an edge in the same cycle is ignored.
  2. Edge in ARMED: the fire is taken. If disarm is also asserted, `sync_out` still pulses and the next state is IDLE.
  3. Disarm: -> IDLE from ARMED or HOLDOFF.
- Edge while IDLE: ignored; no output; `event_count` still increments.
- `sync_armed` is registered state: high in ARMED/HOLDOFF, low in IDLE.
  - Goes high the cycle after arm.
  - In one-shot mode, drops the cycle `sync_out` pulses.
- `sync_fired` holds until the next arm or reset; disarm does not clear it.
- Channels are fully independent; all share the one synchronized edge, so simultaneous fires are allowed.
- Reset asserted mid-holdoff or mid-pulse: outputs clear immediately (async); no pulse is emitted after reset release until a new arm followed by an edge.
- `sync_in` held static produces no edges; the first edge after reset release needs a real transition on the synchronized value, since the reset value of `sync_s_d` is 0.
  - In rising mode with `sync_in` high during reset, the first post-reset detection is therefore a phantom rise and is counted. This is intentional and must be verified.

Test Plan:
- NUM_CHANNELS=1, ONE_SHOT=1, SYNC_STAGES=3; arm, then raise `sync_in` before edge E0 -> `sync_out` high only in the cycle after E0+3; `sync_armed` falls then; `sync_fired`=1; `event_count`=1; a second rising edge gives no pulse and `event_count`=2.
- ONE_SHOT=0, `holdoff_cycles`=4, EDGE_MODE=2; toggle `sync_in` every 2 cycles after arm -> first edge fires; edges during the 4 HOLDOFF cycles are suppressed; the first edge after return to ARMED fires.
- NUM_CHANNELS=2; arm ch0 only; edge -> `sync_out`=2'b01. Then assert arm and disarm on ch1 in the same cycle as the detected edge reaches ch1 -> ch1 ARMED, no pulse on ch1.
- ch0 ARMED; disarm coincident with edge detection -> `sync_out[0]` pulses once, next state IDLE, `sync_armed[0]`=0.
- Assert reset asynchronously mid-HOLDOFF (`holdoff_cycles`=200) -> all outputs 0 immediately; after release, edges give no `sync_out` and `event_count` counts from 0.
- ENABLED=0 with arbitrary arm and `sync_in` activity -> all outputs constant 0; COUNT_WIDTH=4 with 17 edges -> `event_count`=1 (wrap).

Source files
------------

// File: rtl/util_ext_sync_mc.sv
`default_nettype none
// ============================================================================
//  Module      : util_ext_sync_mc
//  Description : Multi-channel external-sync arming block. Synchronizes an
//                asynchronous SYSREF/trigger pin, detects a configurable edge
//                and gates it per channel through an IDLE/ARMED/HOLDOFF FSM,
//                producing one-cycle sync_out pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module util_ext_sync_mc #(
    parameter int ENABLED       = 1,
    parameter int NUM_CHANNELS  = 1,
    parameter int SYNC_STAGES   = 3,
    parameter int EDGE_MODE     = 0,
    parameter int ONE_SHOT      = 1,
    parameter int HOLDOFF_WIDTH = 8,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CHANNELS-1:0]  ext_sync_arm,
    input  logic [NUM_CHANNELS-1:0]  ext_sync_disarm,
    input  logic                     sync_in,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_cycles,
    output logic [NUM_CHANNELS-1:0]  sync_armed,
    output logic [NUM_CHANNELS-1:0]  sync_out,
    output logic [NUM_CHANNELS-1:0]  sync_fired,
    output logic [COUNT_WIDTH-1:0]   event_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    generate
        if (ENABLED != 0) begin : g_enabled
            localparam logic [COUNT_WIDTH-1:0]   c_count_one = COUNT_WIDTH'(1);
            localparam logic [HOLDOFF_WIDTH-1:0] c_hold_one  = HOLDOFF_WIDTH'(1);
            localparam logic [HOLDOFF_WIDTH-1:0] c_hold_zero = '0;

            logic [SYNC_STAGES-1:0] r_sync_chain;
            logic                   r_sync_s_d;
            logic                   w_sync_s;
            logic                   w_edge;
            logic [COUNT_WIDTH-1:0] r_event_count;

            // Synchronizer chain plus one delay flop for edge detection
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync_chain <= '0;
                    r_sync_s_d   <= 1'b0;
                end else begin
                    r_sync_chain <= {r_sync_chain[SYNC_STAGES-2:0], sync_in};
                    r_sync_s_d   <= w_sync_s;
                end
            end

            assign w_sync_s = r_sync_chain[SYNC_STAGES-1];

            if (EDGE_MODE == 0) begin : g_rise
                assign w_edge = w_sync_s & ~r_sync_s_d;
            end else if (EDGE_MODE == 1) begin : g_fall
                assign w_edge = ~w_sync_s & r_sync_s_d;
            end else begin : g_both
                assign w_edge = w_sync_s ^ r_sync_s_d;
            end

            // Free-running count of detected edges, wraps naturally
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_event_count <= '0;
                end else if (w_edge) begin
                    r_event_count <= r_event_count + c_count_one;
                end
            end

            assign event_count = r_event_count;

            for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
                state_t                   r_state;
                state_t                   w_state_nxt;
                logic                     r_out;
                logic                     w_out_nxt;
                logic                     r_fired;
                logic                     w_fired_nxt;
                logic [HOLDOFF_WIDTH-1:0] r_hold;
                logic [HOLDOFF_WIDTH-1:0] w_hold_nxt;

                // Per-channel state, pulse, sticky flag and holdoff counter
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_state <= ST_IDLE;
                        r_out   <= 1'b0;
                        r_fired <= 1'b0;
                        r_hold  <= '0;
                    end else begin
                        r_state <= w_state_nxt;
                        r_out   <= w_out_nxt;
                        r_fired <= w_fired_nxt;
                        r_hold  <= w_hold_nxt;
                    end
                end

                // Next state: arm beats a fire, a fire beats disarm
                always_comb begin
                    w_state_nxt = r_state;
                    w_out_nxt   = 1'b0;
                    w_fired_nxt = r_fired;
                    w_hold_nxt  = r_hold;
                    if (ext_sync_arm[gi]) begin
                        w_state_nxt = ST_ARMED;
                        w_fired_nxt = 1'b0;
                        w_hold_nxt  = '0;
                    end else begin
                        case (r_state)
                            ST_ARMED: begin
                                if (w_edge) begin
                                    w_out_nxt   = 1'b1;
                                    w_fired_nxt = 1'b1;
                                    if (ext_sync_disarm[gi] || (ONE_SHOT != 0)) begin
                                        w_state_nxt = ST_IDLE;
                                    end else if (holdoff_cycles != c_hold_zero) begin
                                        w_state_nxt = ST_HOLDOFF;
                                        w_hold_nxt  = holdoff_cycles;
                                    end
                                end else if (ext_sync_disarm[gi]) begin
                                    w_state_nxt = ST_IDLE;
                                end
                            end
                            ST_HOLDOFF: begin
                                // Counter value N means N cycles remain here
                                if (ext_sync_disarm[gi]) begin
                                    w_state_nxt = ST_IDLE;
                                end else if (r_hold <= c_hold_one) begin
                                    w_state_nxt = ST_ARMED;
                                    w_hold_nxt  = '0;
                                end else begin
                                    w_hold_nxt  = r_hold - c_hold_one;
                                end
                            end
                            default: begin
                                w_state_nxt = ST_IDLE;
                            end
                        endcase
                    end
                end

                assign sync_armed[gi] = (r_state != ST_IDLE);
                assign sync_out[gi]   = r_out;
                assign sync_fired[gi] = r_fired;
            end
        end else begin : g_disabled
            logic w_unused_inputs;
            assign w_unused_inputs = ^{clk, reset, ext_sync_arm, ext_sync_disarm,
                                       sync_in, holdoff_cycles};
            assign sync_armed  = '0;
            assign sync_out    = '0;
            assign sync_fired  = '0;
            assign event_count = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_util_ext_sync_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_util_ext_sync_mc
//  Description : Directed self-checking bench for util_ext_sync_mc using four
//                differently parameterized instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_util_ext_sync_mc;

    logic       clk;
    logic       reset;
    logic       sync_in;
    logic [7:0] holdoff;

    // one-shot, two channels, rising edge
    logic [1:0]  arm_a, disarm_a, armed_a, out_a, fired_a;
    logic [15:0] cnt_a;
    // continuous, both edges
    logic        arm_b, disarm_b, armed_b, out_b, fired_b;
    logic [15:0] cnt_b;
    // disabled
    logic        arm_d, disarm_d, armed_d, out_d, fired_d;
    logic [15:0] cnt_d;
    // 4-bit counter, falling edge
    logic        arm_c, disarm_c, armed_c, out_c, fired_c;
    logic [3:0]  cnt_c;

    int n_checks;
    int n_fail;

    util_ext_sync_mc #(.NUM_CHANNELS(2), .ONE_SHOT(1), .SYNC_STAGES(3), .EDGE_MODE(0)) u_os (
        .clk(clk), .reset(reset), .ext_sync_arm(arm_a), .ext_sync_disarm(disarm_a),
        .sync_in(sync_in), .holdoff_cycles(holdoff), .sync_armed(armed_a),
        .sync_out(out_a), .sync_fired(fired_a), .event_count(cnt_a));

    util_ext_sync_mc #(.NUM_CHANNELS(1), .ONE_SHOT(0), .SYNC_STAGES(3), .EDGE_MODE(2)) u_ct (
        .clk(clk), .reset(reset), .ext_sync_arm(arm_b), .ext_sync_disarm(disarm_b),
        .sync_in(sync_in), .holdoff_cycles(holdoff), .sync_armed(armed_b),
        .sync_out(out_b), .sync_fired(fired_b), .event_count(cnt_b));

    util_ext_sync_mc #(.ENABLED(0)) u_dis (
        .clk(clk), .reset(reset), .ext_sync_arm(arm_d), .ext_sync_disarm(disarm_d),
        .sync_in(sync_in), .holdoff_cycles(holdoff), .sync_armed(armed_d),
        .sync_out(out_d), .sync_fired(fired_d), .event_count(cnt_d));

    util_ext_sync_mc #(.COUNT_WIDTH(4), .EDGE_MODE(1)) u_cw (
        .clk(clk), .reset(reset), .ext_sync_arm(arm_c), .ext_sync_disarm(disarm_c),
        .sync_in(sync_in), .holdoff_cycles(holdoff), .sync_armed(armed_c),
        .sync_out(out_c), .sync_fired(fired_c), .event_count(cnt_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // all stimulus and sampling happens on the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic level);
        step();
        sync_in = level;
        reset   = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_reset();
        step();
        sync_in = 1'b1;
        reset   = 1'b1;
        step();
        step();
        n_checks++;
        if ({armed_a, out_a, fired_a, cnt_a} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_os: got %h expected 0", {armed_a, out_a, fired_a, cnt_a});
        end
        n_checks++;
        if ({armed_b, out_b, fired_b, cnt_b, armed_c, out_c, fired_c, cnt_c} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_others: got %h expected 0",
                     {armed_b, out_b, fired_b, cnt_b, armed_c, out_c, fired_c, cnt_c});
        end
        reset = 1'b0;
        repeat (5) step();
        // sync_in high through reset: rising and both-edge modes see a phantom rise
        n_checks++;
        if (cnt_a !== 16'd1) begin
            n_fail++;
            $display("FAIL phantom_rise_count: got %0d expected 1", cnt_a);
        end
        n_checks++;
        if (cnt_b !== 16'd1 || cnt_c !== 4'd0) begin
            n_fail++;
            $display("FAIL phantom_other_modes: got both=%0d fall=%0d expected 1/0", cnt_b, cnt_c);
        end
        n_checks++;
        if (out_a !== 2'b00) begin
            n_fail++;
            $display("FAIL phantom_no_pulse: got %b expected 00", out_a);
        end
    endtask

    task automatic test_one_shot();
        logic [1:0] seen;
        do_reset(1'b0);
        arm_a = 2'b01;
        step();
        arm_a = 2'b00;
        n_checks++;
        if (armed_a !== 2'b01) begin
            n_fail++;
            $display("FAIL os_armed: got %b expected 01", armed_a);
        end
        sync_in = 1'b1;
        repeat (3) step();
        n_checks++;
        if (out_a !== 2'b00) begin
            n_fail++;
            $display("FAIL os_early: got %b expected 00", out_a);
        end
        step();
        n_checks++;
        if ({out_a, armed_a, fired_a, cnt_a} !== {2'b01, 2'b00, 2'b01, 16'd1}) begin
            n_fail++;
            $display("FAIL os_fire: out=%b armed=%b fired=%b cnt=%0d expected 01/00/01/1",
                     out_a, armed_a, fired_a, cnt_a);
        end
        step();
        n_checks++;
        if (out_a !== 2'b00) begin
            n_fail++;
            $display("FAIL os_pulse_width: got %b expected 00", out_a);
        end
        sync_in = 1'b0;
        repeat (4) step();
        sync_in = 1'b1;
        seen = 2'b00;
        for (int i = 0; i < 6; i++) begin
            step();
            seen |= out_a;
        end
        n_checks++;
        if ({seen, cnt_a, fired_a} !== {2'b00, 16'd2, 2'b01}) begin
            n_fail++;
            $display("FAIL os_second_edge: seen=%b cnt=%0d fired=%b expected 00/2/01",
                     seen, cnt_a, fired_a);
        end
        arm_a = 2'b01;
        step();
        arm_a = 2'b00;
        n_checks++;
        if ({armed_a, fired_a} !== {2'b01, 2'b00}) begin
            n_fail++;
            $display("FAIL os_rearm_clears: armed=%b fired=%b expected 01/00", armed_a, fired_a);
        end
    endtask

    task automatic test_two_channel();
        do_reset(1'b0);
        arm_a = 2'b01;
        step();
        arm_a   = 2'b00;
        sync_in = 1'b1;
        repeat (3) step();
        // edge is being detected this cycle: ch1 arm and disarm coincide with it
        arm_a    = 2'b10;
        disarm_a = 2'b10;
        step();
        arm_a    = 2'b00;
        disarm_a = 2'b00;
        n_checks++;
        if ({out_a, armed_a, fired_a} !== {2'b01, 2'b10, 2'b01}) begin
            n_fail++;
            $display("FAIL two_ch: out=%b armed=%b fired=%b expected 01/10/01",
                     out_a, armed_a, fired_a);
        end
    endtask

    task automatic test_holdoff();
        logic [16:0] out_rec;
        logic [16:0] armed_rec;
        do_reset(1'b0);
        holdoff   = 8'd4;
        out_rec   = '0;
        armed_rec = '0;
        arm_b     = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            step();
            if (t == 1) arm_b = 1'b0;
            out_rec[t]   = out_b;
            armed_rec[t] = armed_b;
            if (t == 1 || t == 3 || t == 5 || t == 7) sync_in = ~sync_in;
        end
        n_checks++;
        if (out_rec !== 17'h00820) begin
            n_fail++;
            $display("FAIL holdoff_pulses: got %b expected %b", out_rec, 17'h00820);
        end
        n_checks++;
        if (armed_rec[16:1] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL holdoff_armed: got %b expected all ones", armed_rec[16:1]);
        end
        n_checks++;
        if (cnt_b !== 16'd4) begin
            n_fail++;
            $display("FAIL holdoff_count: got %0d expected 4", cnt_b);
        end
    endtask

    task automatic test_disarm_on_edge();
        sync_in = 1'b1;
        repeat (3) step();
        disarm_b = 1'b1;
        step();
        disarm_b = 1'b0;
        n_checks++;
        if ({out_b, armed_b, fired_b, cnt_b} !== {1'b1, 1'b0, 1'b1, 16'd5}) begin
            n_fail++;
            $display("FAIL disarm_edge: out=%b armed=%b fired=%b cnt=%0d expected 1/0/1/5",
                     out_b, armed_b, fired_b, cnt_b);
        end
        step();
        n_checks++;
        if ({out_b, armed_b, fired_b} !== 3'b001) begin
            n_fail++;
            $display("FAIL disarm_after: out=%b armed=%b fired=%b expected 0/0/1",
                     out_b, armed_b, fired_b);
        end
    endtask

    task automatic test_reset_mid_holdoff();
        logic seen;
        do_reset(1'b0);
        holdoff = 8'd200;
        arm_b   = 1'b1;
        step();
        arm_b   = 1'b0;
        sync_in = 1'b1;
        repeat (4) step();
        n_checks++;
        if (out_b !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_fire: got %b expected 1", out_b);
        end
        sync_in = 1'b0;
        repeat (2) step();
        n_checks++;
        if ({armed_b, out_b} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_in_holdoff: armed/out got %b expected 10", {armed_b, out_b});
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({armed_b, out_b, fired_b, cnt_b} !== 19'd0) begin
            n_fail++;
            $display("FAIL mid_async_clear: got %h expected 0", {armed_b, out_b, fired_b, cnt_b});
        end
        step();
        step();
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1 || i == 5) sync_in = ~sync_in;
            step();
            seen |= out_b;
        end
        n_checks++;
        if ({seen, armed_b, cnt_b} !== {1'b0, 1'b0, 16'd2}) begin
            n_fail++;
            $display("FAIL post_reset: seen=%b armed=%b cnt=%0d expected 0/0/2", seen, armed_b, cnt_b);
        end
    endtask

    task automatic test_disabled();
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            arm_d    = 1'($urandom);
            disarm_d = 1'($urandom);
            if (i % 2 == 0) sync_in = ~sync_in;
            step();
            n_checks++;
            if ({armed_d, out_d, fired_d, cnt_d} !== 19'd0) begin
                n_fail++;
                $display("FAIL disabled_outputs: got %h expected 0", {armed_d, out_d, fired_d, cnt_d});
            end
        end
        arm_d    = 1'b0;
        disarm_d = 1'b0;
    endtask

    task automatic test_count_wrap();
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) begin
            sync_in = 1'b1;
            step();
            step();
            sync_in = 1'b0;
            step();
            step();
            if (i == 14) begin
                repeat (4) step();
                n_checks++;
                if (cnt_c !== 4'd15) begin
                    n_fail++;
                    $display("FAIL count_15: got %0d expected 15", cnt_c);
                end
            end
        end
        repeat (5) step();
        n_checks++;
        if (cnt_c !== 4'd1) begin
            n_fail++;
            $display("FAIL count_wrap: got %0d expected 1", cnt_c);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        sync_in  = 1'b0;
        holdoff  = 8'd0;
        arm_a = 2'b00; disarm_a = 2'b00;
        arm_b = 1'b0;  disarm_b = 1'b0;
        arm_c = 1'b0;  disarm_c = 1'b0;
        arm_d = 1'b0;  disarm_d = 1'b0;

        test_reset();
        test_one_shot();
        test_two_channel();
        test_holdoff();
        test_disarm_on_edge();
        test_reset_mid_holdoff();
        test_disabled();
        test_count_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
